// File: rtl/axi_apb_sequencer.sv
// AXI4-Lite slave to APB-master sequencer: arbitrates one write or read at a time onto an APB
// request interface. Optional macro WSTRB_CHECK_EN rejects partial-strobe writes with SLVERR.
`timescale 1ns/1ps
module axi_apb_sequencer #(
  parameter int unsigned C_RD_FIRST = 0
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        S_AWVALID,
  output logic        S_AWREADY,
  input  logic [31:0] S_AWADDR,
  input  logic        S_WVALID,
  output logic        S_WREADY,
  input  logic [31:0] S_WDATA,
  input  logic [3:0]  S_WSTRB,
  output logic        S_BVALID,
  input  logic        S_BREADY,
  output logic [1:0]  S_BRESP,
  input  logic        S_ARVALID,
  output logic        S_ARREADY,
  input  logic [31:0] S_ARADDR,
  output logic        S_RVALID,
  input  logic        S_RREADY,
  output logic [31:0] S_RDATA,
  output logic [1:0]  S_RRESP,
  output logic        STREQ,
  output logic        SWRT,
  output logic        SSEL,
  output logic [31:0] SADDR,
  output logic [31:0] SWDATA,
  input  logic [31:0] SRDATA,
  input  logic        PENABLE,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [2:0] {StIdle, StWrXfer, StRdXfer, StWrResp, StRdResp} state_e;

  state_e      state_q, state_d;
  logic        rd_prio_q, rd_prio_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wr_pend, rd_pend, grant_wr, grant_rd, apb_done, wstrb_bad;

`ifdef WSTRB_CHECK_EN
  assign wstrb_bad = (S_WSTRB != 4'b1111);
`else
  logic unused_wstrb;
  assign unused_wstrb = ^S_WSTRB;
  assign wstrb_bad    = 1'b0;
`endif

  assign wr_pend  = S_AWVALID & S_WVALID;
  assign rd_pend  = S_ARVALID;
  // rd_prio_q names the type that wins a tie; it flips to the other type on every grant.
  assign grant_wr = wr_pend & (~rd_pend | ~rd_prio_q);
  assign grant_rd = rd_pend & (~wr_pend | rd_prio_q);
  assign apb_done = PENABLE & PREADY;

  assign SADDR   = addr_q;
  assign SWDATA  = wdata_q;
  assign S_RDATA = rdata_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      rd_prio_q <= (C_RD_FIRST != 0);
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_prio_q <= rd_prio_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_prio_d = rd_prio_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    S_AWREADY = 1'b0;
    S_WREADY  = 1'b0;
    S_ARREADY = 1'b0;
    S_BVALID  = 1'b0;
    S_BRESP   = 2'b00;
    S_RVALID  = 1'b0;
    S_RRESP   = 2'b00;
    STREQ     = 1'b0;
    SWRT      = 1'b0;
    SSEL      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_wr) begin
          S_AWREADY = 1'b1;
          S_WREADY  = 1'b1;
          addr_d    = S_AWADDR;
          wdata_d   = S_WDATA;
          rd_prio_d = 1'b1;
          err_d     = wstrb_bad;
          state_d   = wstrb_bad ? StWrResp : StWrXfer;
        end else if (grant_rd) begin
          S_ARREADY = 1'b1;
          addr_d    = S_ARADDR;
          rd_prio_d = 1'b0;
          state_d   = StRdXfer;
        end
      end
      StWrXfer, StRdXfer: begin
        SSEL  = 1'b1;
        SWRT  = (state_q == StWrXfer);
        // Dropping STREQ in the completion cycle keeps the master from starting a second transfer.
        STREQ = ~apb_done;
        if (apb_done) begin
          err_d = PSLVERR;
          if (state_q == StRdXfer) begin
            rdata_d = SRDATA;
            state_d = StRdResp;
          end else begin
            state_d = StWrResp;
          end
        end
      end
      StWrResp: begin
        S_BVALID = 1'b1;
        S_BRESP  = err_q ? 2'b10 : 2'b00;
        if (S_BREADY) state_d = StIdle;
      end
      StRdResp: begin
        S_RVALID = 1'b1;
        S_RRESP  = err_q ? 2'b10 : 2'b00;
        if (S_RREADY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_axi_apb_sequencer.sv
// Directed self-checking bench for axi_apb_sequencer with a small APB master model
// (IDLE -> SETUP -> ACCESS, programmable wait states) answering STREQ.
`timescale 1ns/1ps
module tb_axi_apb_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        S_AWVALID = 1'b0, S_WVALID = 1'b0, S_ARVALID = 1'b0;
  logic        S_BREADY = 1'b0, S_RREADY = 1'b0;
  logic [31:0] S_AWADDR = '0, S_WDATA = '0, S_ARADDR = '0;
  logic [3:0]  S_WSTRB = 4'hF;
  logic        S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID;
  logic [1:0]  S_BRESP, S_RRESP;
  logic [31:0] S_RDATA, SADDR, SWDATA, SRDATA;
  logic        STREQ, SWRT, SSEL, PENABLE, PREADY, PSLVERR;

  int          passed = 0;
  int          total = 0;
  int          wait_cfg = 0;
  logic        pslverr_cfg = 1'b0;
  logic [31:0] srdata_cfg = '0;

  typedef enum logic [1:0] {ApbIdle, ApbSetup, ApbAccess} apb_e;
  apb_e apb_st;
  int   wait_left;
  int   apb_xfers = 0;

  always #5 PCLK = ~PCLK;

  axi_apb_sequencer dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .S_AWVALID (S_AWVALID),
    .S_AWREADY (S_AWREADY),
    .S_AWADDR  (S_AWADDR),
    .S_WVALID  (S_WVALID),
    .S_WREADY  (S_WREADY),
    .S_WDATA   (S_WDATA),
    .S_WSTRB   (S_WSTRB),
    .S_BVALID  (S_BVALID),
    .S_BREADY  (S_BREADY),
    .S_BRESP   (S_BRESP),
    .S_ARVALID (S_ARVALID),
    .S_ARREADY (S_ARREADY),
    .S_ARADDR  (S_ARADDR),
    .S_RVALID  (S_RVALID),
    .S_RREADY  (S_RREADY),
    .S_RDATA   (S_RDATA),
    .S_RRESP   (S_RRESP),
    .STREQ     (STREQ),
    .SWRT      (SWRT),
    .SSEL      (SSEL),
    .SADDR     (SADDR),
    .SWDATA    (SWDATA),
    .SRDATA    (SRDATA),
    .PENABLE   (PENABLE),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  // APB master model: samples STREQ in IDLE, then SETUP, then ACCESS with wait_cfg wait states.
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      apb_st    <= ApbIdle;
      wait_left <= 0;
    end else begin
      case (apb_st)
        ApbIdle:  if (STREQ === 1'b1) apb_st <= ApbSetup;
        ApbSetup: begin
          apb_st    <= ApbAccess;
          wait_left <= wait_cfg;
        end
        default: begin
          if (wait_left == 0) begin
            apb_st    <= ApbIdle;
            apb_xfers <= apb_xfers + 1;
          end else begin
            wait_left <= wait_left - 1;
          end
        end
      endcase
    end
  end

  assign PENABLE = (apb_st == ApbAccess);
  assign PREADY  = PENABLE && (wait_left == 0);
  assign PSLVERR = pslverr_cfg;
  assign SRDATA  = srdata_cfg;

  task automatic apply_reset();
    PRESETn = 1'b0;
    {S_AWVALID, S_WVALID, S_ARVALID, S_BREADY, S_RREADY} = '0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
  endtask

  task automatic wait_resp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (S_BVALID === 1'b1 || S_RVALID === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge PCLK);
    end
  endtask

  task automatic test_reset();
    @(negedge PCLK);
    total++;
    if ({S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID, STREQ, SSEL, SWRT} !== 8'h00)
      $display("FAIL rst_ctl: got %b want 00000000",
               {S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID, STREQ, SSEL, SWRT});
    else passed++;
    total++;
    if (SADDR !== 32'h0) $display("FAIL rst_saddr: got %h want 0", SADDR); else passed++;
    total++;
    if (SWDATA !== 32'h0) $display("FAIL rst_swdata: got %h want 0", SWDATA); else passed++;
    total++;
    if (S_RDATA !== 32'h0) $display("FAIL rst_rdata: got %h want 0", S_RDATA); else passed++;
    total++;
    if ({S_BRESP, S_RRESP} !== 4'h0) $display("FAIL rst_resp: got %b want 0000", {S_BRESP, S_RRESP});
    else passed++;
    PRESETn = 1'b1;
    @(negedge PCLK);
  endtask

  task automatic test_write();
    int streq_n = 0;
    int bad = 0;
    int x0;
    bit got = 1'b0;
    x0 = apb_xfers;
    wait_cfg = 0;
    pslverr_cfg = 1'b0;
    S_AWADDR = 32'h0000_0010; S_WDATA = 32'hDEAD_BEEF; S_WSTRB = 4'hF;
    S_AWVALID = 1'b1; S_WVALID = 1'b1;
    #1;
    total++;
    if ({S_AWREADY, S_WREADY, S_ARREADY} !== 3'b110)
      $display("FAIL wr_grant: got %b want 110", {S_AWREADY, S_WREADY, S_ARREADY});
    else passed++;
    @(negedge PCLK);
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (S_BVALID === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (STREQ === 1'b1) begin
        streq_n++;
        if (SWRT !== 1'b1 || SSEL !== 1'b1 || SADDR !== 32'h10 || SWDATA !== 32'hDEAD_BEEF) bad++;
      end
      if ({S_AWREADY, S_WREADY, S_ARREADY} !== 3'b000) bad++;
      @(negedge PCLK);
    end
    total++;
    if (!got) $display("FAIL wr_bvalid: no BVALID within 50 cycles"); else passed++;
    total++;
    if (streq_n != 2) $display("FAIL wr_streq_cycles: got %0d want 2", streq_n); else passed++;
    total++;
    if (bad != 0) $display("FAIL wr_apb_ctl: %0d bad cycles want 0", bad); else passed++;
    total++;
    if (S_BRESP !== 2'b00) $display("FAIL wr_bresp: got %b want 00", S_BRESP); else passed++;
    total++;
    if (apb_xfers - x0 != 1) $display("FAIL wr_xfers: got %0d want 1", apb_xfers - x0);
    else passed++;
    S_BREADY = 1'b1;
    @(negedge PCLK);
    S_BREADY = 1'b0;
    total++;
    if (S_BVALID !== 1'b0) $display("FAIL wr_bvalid_drop: got %b want 0", S_BVALID); else passed++;
  endtask

  task automatic test_read_wait();
    int streq_n = 0;
    int ssel_n = 0;
    int bad = 0;
    bit got = 1'b0;
    wait_cfg = 3;
    pslverr_cfg = 1'b0;
    srdata_cfg = 32'h1234_5678;
    S_ARADDR = 32'h0000_0020; S_ARVALID = 1'b1;
    #1;
    total++;
    if ({S_AWREADY, S_WREADY, S_ARREADY} !== 3'b001)
      $display("FAIL rd_grant: got %b want 001", {S_AWREADY, S_WREADY, S_ARREADY});
    else passed++;
    @(negedge PCLK);
    S_ARVALID = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (S_RVALID === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (SSEL === 1'b1) begin
        ssel_n++;
        if (SWRT !== 1'b0 || SADDR !== 32'h20) bad++;
      end
      if (STREQ === 1'b1) streq_n++;
      @(negedge PCLK);
    end
    total++;
    if (!got) $display("FAIL rd_rvalid: no RVALID within 50 cycles"); else passed++;
    total++;
    if (ssel_n != 6) $display("FAIL rd_xfer_cycles: got %0d want 6", ssel_n); else passed++;
    total++;
    if (streq_n != 5) $display("FAIL rd_streq_cycles: got %0d want 5", streq_n); else passed++;
    total++;
    if (bad != 0) $display("FAIL rd_apb_ctl: %0d bad cycles want 0", bad); else passed++;
    total++;
    if (S_RDATA !== 32'h1234_5678) $display("FAIL rd_rdata: got %h want 12345678", S_RDATA);
    else passed++;
    total++;
    if (S_RRESP !== 2'b00) $display("FAIL rd_rresp: got %b want 00", S_RRESP); else passed++;
    S_RREADY = 1'b1;
    @(negedge PCLK);
    S_RREADY = 1'b0;
    wait_cfg = 0;
  endtask

  task automatic test_arbitration();
    int miss = 0;
    bit got;
    logic [1:0] g;
    logic [1:0] exp_g;
    apply_reset();
    wait_cfg = 0;
    pslverr_cfg = 1'b0;
    for (int k = 0; k < 4; k++) begin
      S_AWADDR = 32'h100 + k; S_WDATA = 32'hA000 + k; S_ARADDR = 32'h200 + k;
      S_AWVALID = 1'b1; S_WVALID = 1'b1; S_ARVALID = 1'b1;
      #1;
      g = {S_AWREADY & S_WREADY, S_ARREADY};
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
      total++;
      if (g !== exp_g) $display("FAIL arb_grant%0d: got %b want %b (W,R)", k, g, exp_g);
      else passed++;
      @(negedge PCLK);
      S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
      wait_resp(got);
      if (!got) miss++;
      S_BREADY = 1'b1; S_RREADY = 1'b1;
      @(negedge PCLK);
      S_BREADY = 1'b0; S_RREADY = 1'b0;
    end
    total++;
    if (miss != 0) $display("FAIL arb_resp: %0d missing responses want 0", miss); else passed++;
  endtask

  task automatic test_slverr_hold();
    int bad = 0;
    bit got;
    wait_cfg = 0;
    pslverr_cfg = 1'b1;
    srdata_cfg = 32'hCAFE_0001;
    S_ARADDR = 32'h30; S_ARVALID = 1'b1;
    @(negedge PCLK);
    S_ARVALID = 1'b0;
    wait_resp(got);
    total++;
    if (!got || S_RVALID !== 1'b1) $display("FAIL err_rvalid: got %b want 1", S_RVALID); else passed++;
    pslverr_cfg = 1'b0;
    S_ARADDR = 32'h34; S_ARVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (S_RVALID !== 1'b1 || S_RRESP !== 2'b10 || S_RDATA !== 32'hCAFE_0001 ||
          S_ARREADY !== 1'b0 || STREQ !== 1'b0) bad++;
      @(negedge PCLK);
    end
    total++;
    if (bad != 0) $display("FAIL err_hold: %0d unstable cycles want 0", bad); else passed++;
    S_RREADY = 1'b1;
    #1;
    total++;
    if (S_ARREADY !== 1'b0) $display("FAIL err_early_grant: ARREADY got %b want 0", S_ARREADY);
    else passed++;
    @(negedge PCLK);
    S_RREADY = 1'b0;
    total++;
    if ({S_RVALID, S_ARREADY} !== 2'b01)
      $display("FAIL err_regrant: {RVALID,ARREADY} got %b want 01", {S_RVALID, S_ARREADY});
    else passed++;
    srdata_cfg = 32'h0000_5A5A;
    @(negedge PCLK);
    S_ARVALID = 1'b0;
    wait_resp(got);
    total++;
    if (!got || S_RRESP !== 2'b00 || S_RDATA !== 32'h0000_5A5A)
      $display("FAIL err_next_rd: rresp %b rdata %h want 00 00005a5a", S_RRESP, S_RDATA);
    else passed++;
    S_RREADY = 1'b1;
    @(negedge PCLK);
    S_RREADY = 1'b0;
  endtask

  task automatic test_wstrb();
    int streq_n = 0;
    int x0;
    bit got = 1'b0;
    int exp_streq;
    int exp_xfers;
    logic [1:0] exp_resp;
`ifdef WSTRB_CHECK_EN
    exp_streq = 0; exp_xfers = 0; exp_resp = 2'b10;
`else
    exp_streq = 2; exp_xfers = 1; exp_resp = 2'b00;
`endif
    x0 = apb_xfers;
    wait_cfg = 0;
    S_AWADDR = 32'h40; S_WDATA = 32'h55AA_55AA; S_WSTRB = 4'b0011;
    S_AWVALID = 1'b1; S_WVALID = 1'b1;
    @(negedge PCLK);
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (S_BVALID === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (STREQ === 1'b1) streq_n++;
      @(negedge PCLK);
    end
    S_WSTRB = 4'hF;
    total++;
    if (!got) $display("FAIL strb_bvalid: no BVALID within 50 cycles"); else passed++;
    total++;
    if (streq_n != exp_streq) $display("FAIL strb_streq: got %0d want %0d", streq_n, exp_streq);
    else passed++;
    total++;
    if (S_BRESP !== exp_resp) $display("FAIL strb_bresp: got %b want %b", S_BRESP, exp_resp);
    else passed++;
    total++;
    if (apb_xfers - x0 != exp_xfers)
      $display("FAIL strb_xfers: got %0d want %0d", apb_xfers - x0, exp_xfers);
    else passed++;
    S_BREADY = 1'b1;
    @(negedge PCLK);
    S_BREADY = 1'b0;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    int x0;
    wait_cfg = 10;
    srdata_cfg = 32'h0BAD_F00D;
    S_ARADDR = 32'h50; S_ARVALID = 1'b1;
    @(negedge PCLK);
    S_ARVALID = 1'b0;
    repeat (3) @(negedge PCLK);
    total++;
    if ({SSEL, STREQ, PENABLE, PREADY} !== 4'b1110)
      $display("FAIL mid_wait_state: {SSEL,STREQ,PENABLE,PREADY} got %b want 1110",
               {SSEL, STREQ, PENABLE, PREADY});
    else passed++;
    #2;
    PRESETn = 1'b0;
    #1;
    total++;
    if ({S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID, STREQ, SSEL, SWRT} !== 8'h00)
      $display("FAIL mid_rst_ctl: got %b want 00000000",
               {S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID, STREQ, SSEL, SWRT});
    else passed++;
    total++;
    if ({SADDR, SWDATA, S_RDATA} !== 96'h0)
      $display("FAIL mid_rst_data: saddr %h swdata %h rdata %h want 0", SADDR, SWDATA, S_RDATA);
    else passed++;
    total++;
    if ({S_BRESP, S_RRESP} !== 4'h0)
      $display("FAIL mid_rst_resp: got %b want 0000", {S_BRESP, S_RRESP});
    else passed++;
    @(negedge PCLK);
    PRESETn = 1'b1;
    wait_cfg = 0;
    x0 = apb_xfers;
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      if (S_RVALID !== 1'b0 || S_BVALID !== 1'b0 || STREQ !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL mid_no_resp: %0d cycles with activity want 0", bad); else passed++;
    total++;
    if (apb_xfers != x0) $display("FAIL mid_no_xfer: got %0d want 0", apb_xfers - x0);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_arbitration();
    test_slverr_hold();
    test_wstrb();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_apb_sequencer.md
AXI_APB_SEQUENCER -- requirements
Module: axi_apb_sequencer

Interface
REQ-001 SHALL have parameter C_RD_FIRST, default 0, meaning initial arbitration priority after reset (0 = write first, 1 = read first).
REQ-002 SHALL have ports (PCLK, PRESETn first): PCLK in 1 clock; PRESETn in 1 asynchronous active-low reset.
REQ-003 SHALL have AXI4-Lite write ports: S_AWVALID in 1; S_AWREADY out 1; S_AWADDR in 32; S_WVALID in 1; S_WREADY out 1; S_WDATA in 32; S_WSTRB in 4; S_BVALID out 1; S_BREADY in 1; S_BRESP out 2.
REQ-004 SHALL have AXI4-Lite read ports: S_ARVALID in 1; S_ARREADY out 1; S_ARADDR in 32; S_RVALID out 1; S_RREADY in 1; S_RDATA out 32; S_RRESP out 2.
REQ-005 SHALL have APB-master control ports: STREQ out 1 transfer request; SWRT out 1 write/read; SSEL out 1 slave select; SADDR out 32; SWDATA out 32; SRDATA in 32 read data; PENABLE in 1; PREADY in 1; PSLVERR in 1.

Function
REQ-006 SHALL implement states IDLE, WR_XFER, RD_XFER, WR_RESP, RD_RESP.
REQ-007 In IDLE, a write is pending when S_AWVALID and S_WVALID are both 1; a read is pending when S_ARVALID is 1.
REQ-008 With only one pending, SHALL grant it; with both pending, SHALL grant the type not granted last (round-robin), first tie after reset per C_RD_FIRST.
REQ-009 On a write grant, SHALL assert S_AWREADY and S_WREADY for exactly that one cycle, latch S_AWADDR/S_WDATA, and go to WR_XFER.
REQ-010 On a read grant, SHALL assert S_ARREADY for exactly that one cycle, latch S_ARADDR, and go to RD_XFER.
REQ-011 SHALL never assert a READY outside IDLE; AW and W are accepted only together.
REQ-012 In WR_XFER/RD_XFER, SHALL drive SSEL=1, SADDR=latched address, SWDATA=latched data, SWRT=1 for write and 0 for read.
REQ-013 In XFER states, SHALL drive STREQ = NOT(PENABLE AND PREADY) combinationally, so that STREQ is low in the completion cycle and exactly one APB transfer is issued per grant.
REQ-014 On completion (PENABLE AND PREADY in an XFER state), SHALL latch PSLVERR and, for reads, SRDATA; then go to WR_RESP or RD_RESP.
REQ-015 Wait states (PENABLE=1, PREADY=0) SHALL hold the XFER state and all S* outputs unchanged, with no limit.
REQ-016 WR_RESP SHALL drive S_BVALID=1 and S_BRESP=2'b10 if the latched error is set, else 2'b00; it returns to IDLE on the cycle S_BREADY=1.
REQ-017 RD_RESP SHALL drive S_RVALID=1, S_RDATA=latched data, and S_RRESP as in REQ-016; it returns to IDLE on the cycle S_RREADY=1.
REQ-018 BVALID/RVALID, once set, SHALL hold with stable BRESP/RDATA/RRESP until accepted; the next grant SHALL come no earlier than the cycle after return to IDLE.
REQ-019 Outside XFER states, SHALL drive STREQ=0, SSEL=0, SWRT=0; SADDR/SWDATA SHALL hold their last latched values.

Reset
REQ-020 PRESETn low SHALL immediately force: state IDLE; all READY/VALID outputs 0; STREQ, SSEL, SWRT 0; SADDR, SWDATA, S_RDATA 0; S_BRESP, S_RRESP 0; priority per C_RD_FIRST.
REQ-021 Reset asserted mid-transfer or mid-response SHALL discard that transaction with no response issued.

Configuration
REQ-022 With macro WSTRB_CHECK_EN defined, a granted write with S_WSTRB != 4'b1111 SHALL skip WR_XFER, issue no APB transfer, and go directly to WR_RESP with S_BRESP=2'b10.
REQ-023 Without WSTRB_CHECK_EN, S_WSTRB SHALL be ignored and every granted write SHALL be issued on APB.

Verification
REQ-024 Write AW=0x0000_0010, W=0xDEAD_BEEF, PREADY=1 at first access -> STREQ high for exactly 2 cycles, SWRT=1, SADDR=0x10, BVALID with BRESP=00.
REQ-025 Read AR=0x0000_0020, SRDATA=0x1234_5678, PREADY low for 3 access cycles -> XFER held 3 extra cycles, then RVALID with RDATA=0x1234_5678, RRESP=00.
REQ-026 AW/W and AR valid in the same cycle, repeated 4 times, C_RD_FIRST=0 -> grant order W,R,W,R.
REQ-027 Read with PSLVERR=1 at completion and RREADY held low 5 cycles -> RVALID held 5+ cycles, RRESP=10 stable, no new grant.
REQ-028 WSTRB=4'b0011 with WSTRB_CHECK_EN defined -> STREQ never asserted, BRESP=10; undefined -> normal APB write, BRESP=00.
REQ-029 PRESETn pulsed low during RD_XFER wait state -> all outputs per REQ-020 in the same cycle, no RVALID afterwards.
